// File: rtl/vga_mode_pkg.sv
// Shared types for the VGA mode-switch sequencer: timing preset record,
// derived band-line record, FSM states and the four-entry preset table.
package vga_mode_pkg;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_start;
        logic [11:0] v_end;
    } preset_t;

    typedef struct packed {
        logic [11:0] a14;
        logic [11:0] a24;
        logic [11:0] a34;
    } band_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_PLL_REQ    = 3'd2,
        ST_PLL_REL    = 3'd3,
        ST_LOAD       = 3'd4,
        ST_SETTLE     = 3'd5
    } state_e;

    // Totals and sync widths are stored minus one; h_start is three pixels
    // early to cover the generator's pixel pipeline.
    function automatic preset_t preset_lookup(input logic [1:0] idx);
        preset_t p;
        case (idx)
            2'd0:    p = '{12'd799,  12'd95,  12'd141, 12'd781,
                           12'd524,  12'd1,   12'd34,  12'd514};
            2'd1:    p = '{12'd1055, 12'd127, 12'd213, 12'd1013,
                           12'd627,  12'd3,   12'd26,  12'd626};
            2'd2:    p = '{12'd1343, 12'd135, 12'd293, 12'd1317,
                           12'd805,  12'd5,   12'd34,  12'd802};
            2'd3:    p = '{12'd1687, 12'd111, 12'd357, 12'd1637,
                           12'd1065, 12'd2,   12'd40,  12'd1064};
            default: p = '{12'd799,  12'd95,  12'd141, 12'd781,
                           12'd524,  12'd1,   12'd34,  12'd514};
        endcase
        return p;
    endfunction

    function automatic band_t band_lines(input logic [11:0] v_start,
                                         input logic [11:0] v_end);
        band_t       b;
        logic [11:0] span;
        span  = v_end - v_start;
        b.a14 = v_start + (span >> 2);
        b.a24 = v_start + (span >> 1);
        b.a34 = v_start + (span >> 1) + (span >> 2);
        return b;
    endfunction

endpackage

// File: rtl/vga_band_calc.sv
// Registered quarter-band line derivation; new values are taken only on load_i
// so the band outputs change in the same cycle as the timing words.
module vga_band_calc
    import vga_mode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [11:0] v_start_i,
    input  logic [11:0] v_end_i,
    output logic [11:0] v_active_14_o,
    output logic [11:0] v_active_24_o,
    output logic [11:0] v_active_34_o
);

    localparam preset_t P0       = preset_lookup(2'd0);
    localparam band_t   BAND_RST = band_lines(P0.v_start, P0.v_end);

    band_t band_q;

    // Band register: preset-0 bands after reset, recomputed on load
    always_ff @(posedge clk) begin
        if (reset) begin
            band_q <= BAND_RST;
        end else if (load_i) begin
            band_q <= band_lines(v_start_i, v_end_i);
        end else begin
            band_q <= band_q;
        end
    end

    assign v_active_14_o = band_q.a14;
    assign v_active_24_o = band_q.a24;
    assign v_active_34_o = band_q.a34;

endmodule

// File: rtl/vga_mode_ctrl.sv
// Mode-switch sequencer: blanks the VGA timing generator at a frame boundary,
// handshakes with the pixel-PLL reconfig block, then loads a new timing preset.
module vga_mode_ctrl
    import vga_mode_pkg::*;
#(
    parameter int VS_TIMEOUT    = 2_000_000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode_sel,
    input  logic        mode_req,
    input  logic        vga_vs,
    input  logic        pll_ack,
    output logic        pll_req,
    output logic [1:0]  pll_mode,
    output logic        gen_reset_n,
    output logic        busy,
    output logic [1:0]  cur_mode,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_active_14,
    output logic [11:0] v_active_24,
    output logic [11:0] v_active_34
);

    localparam logic [CNT_W-1:0] VS_LAST     = CNT_W'(VS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam preset_t          PRESET_RST  = preset_lookup(2'd0);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q, pend_d;
    logic [1:0]       pend_mode_q, pend_mode_d;
    logic [1:0]       tgt_q, cur_mode_q, pll_mode_q;
    logic             pll_req_q, gen_reset_n_q, busy_q, vs_d_q;
    preset_t          timing_q, tgt_preset_s;
    logic             frame_edge_s, load_s;

    assign frame_edge_s = vs_d_q & ~vga_vs;
    assign load_s       = (state_q == ST_LOAD);
    assign tgt_preset_s = preset_lookup(tgt_q);

    // Pending request: a new strobe always wins over IDLE consuming the old one
    always_comb begin
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        if (mode_req) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_sel;
        end else if (state_q == ST_IDLE && pend_q) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Pending register and vsync delay for frame-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_mode_q <= 2'd0;
            vs_d_q      <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
            vs_d_q      <= vga_vs;
        end
    end

    // Switch sequencer with registered handshake, reset and timing outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SETTLE;
            cnt_q         <= '0;
            gen_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
            pll_req_q     <= 1'b0;
            pll_mode_q    <= 2'd0;
            cur_mode_q    <= 2'd0;
            tgt_q         <= 2'd0;
            timing_q      <= PRESET_RST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_q && (pend_mode_q != cur_mode_q)) begin
                        tgt_q   <= pend_mode_q;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_edge_s || (cnt_q == VS_LAST)) begin
                        gen_reset_n_q <= 1'b0;
                        pll_req_q     <= 1'b1;
                        pll_mode_q    <= tgt_q;
                        state_q       <= ST_PLL_REQ;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PLL_REQ: begin
                    if (pll_ack) begin
                        pll_req_q <= 1'b0;
                        state_q   <= ST_PLL_REL;
                    end
                end
                ST_PLL_REL: begin
                    if (!pll_ack) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    timing_q   <= tgt_preset_s;
                    cur_mode_q <= tgt_q;
                    cnt_q      <= '0;
                    state_q    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == SETTLE_LAST) begin
                        gen_reset_n_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q       <= ST_SETTLE;
                    cnt_q         <= '0;
                    gen_reset_n_q <= 1'b0;
                    busy_q        <= 1'b1;
                    pll_req_q     <= 1'b0;
                end
            endcase
        end
    end

    vga_band_calc u_band (
        .clk           (clk),
        .reset         (reset),
        .load_i        (load_s),
        .v_start_i     (tgt_preset_s.v_start),
        .v_end_i       (tgt_preset_s.v_end),
        .v_active_14_o (v_active_14),
        .v_active_24_o (v_active_24),
        .v_active_34_o (v_active_34)
    );

    assign pll_req     = pll_req_q;
    assign pll_mode    = pll_mode_q;
    assign gen_reset_n = gen_reset_n_q;
    assign busy        = busy_q;
    assign cur_mode    = cur_mode_q;
    assign h_total     = timing_q.h_total;
    assign h_sync      = timing_q.h_sync;
    assign h_start     = timing_q.h_start;
    assign h_end       = timing_q.h_end;
    assign v_total     = timing_q.v_total;
    assign v_sync      = timing_q.v_sync;
    assign v_start     = timing_q.v_start;
    assign v_end       = timing_q.v_end;

endmodule
